axis_checker: RTL and testbench
===============================

AXIS_CHECKER -- requirements
Module: axis_checker

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 32: width of every packet counter.
REQ-002 SHALL have parameter TDEST, default 0: the local destination ID this checker accepts.
REQ-003 SHALL have parameters TDATA_WIDTH 64, TDEST_WIDTH 2, TID_WIDTH 2 (AXI-Stream field widths), and NUM_ROUTERS 4 (number of traffic sources).
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  single clock for all logic.
- rst  in  1  reset, synchronous and active-high.
- ticks  in  TDATA_WIDTH/2  free-running global timestamp.
- axis_in_tvalid, axis_in_tready(out), axis_in_tdata, axis_in_tlast, axis_in_tid, axis_in_tdest  in  1/1/TDATA_WIDTH/1/TID_WIDTH/TDEST_WIDTH  AXI-Stream slave.
- recv_packets  out  [NUM_ROUTERS] x COUNT_WIDTH  packets received per source tid.
- total_recv_packets  out  COUNT_WIDTH  packets received from all sources.
- error  out  1  sticky error flag.

Function
REQ-005 SHALL register axis_in_tready and hold it at 1 in every cycle after reset deasserts; the block never back-pressures.
REQ-006 A beat is accepted when tvalid and tready are both 1; all checks apply only to accepted beats.
REQ-007 SHALL track packet boundaries with an in_packet flag:
- A beat accepted with in_packet=0 is the header beat.
- An accepted beat with tlast=1 clears the flag.
REQ-008 Header beat fields:
- tdata[TDATA_WIDTH/2-1:0] is the per-(source, destination) sequence number.
- tdata[TDATA_WIDTH-1:TDATA_WIDTH/2] is the send timestamp.
REQ-009 Header check: SHALL set error if tdest != TDEST, or tid >= NUM_ROUTERS, or the sequence number != recv_packets[tid] (compare the low min(COUNT_WIDTH, TDATA_WIDTH/2) bits).
REQ-010 Non-header beats: SHALL set error if tid or tdest differs from the header beat of the same packet.
REQ-011 On an accepted beat with tlast=1, recv_packets[tid] and total_recv_packets SHALL each increment by 1 on the next clk edge.
- Counters wrap modulo 2^COUNT_WIDTH.
- A single-beat packet is checked and counted in the same cycle.
- An out-of-range tid updates total_recv_packets only.
REQ-012 error SHALL be sticky until reset; counting continues after an error.
REQ-013 Outputs SHALL be registered, with 1-cycle latency from the accepting edge.
REQ-014 Back-to-back packets on consecutive cycles SHALL each be checked and counted with no lost beats.

Reset
REQ-015 While rst=1 (sampled on clk), on the next edge: all recv_packets = 0, total_recv_packets = 0, error = 0, in_packet = 0, axis_in_tready = 0.
REQ-016 Asserting rst mid-packet SHALL discard the partial packet and leave no residual state.

Configuration
REQ-017 Macro AXIS_CHECKER_LATENCY_STATS_EN, when defined, SHALL add these outputs, reset to 0:
- max_latency (TDATA_WIDTH/2): maximum of (ticks - header timestamp), modulo 2^(TDATA_WIDTH/2), sampled on each counted packet's tlast beat.
- sum_latency (COUNT_WIDTH+TDATA_WIDTH/2): running total of those latencies.
REQ-018 Without the macro, those ports and that logic SHALL be absent; all other behaviour is identical.

Structure
REQ-019 Header-field slicing widths and the sequence-compare width SHALL be localparams in a shared package, axis_noc_pkg, that the traffic generator also uses.
REQ-020 The latency accumulator SHALL be one sub-module, axis_checker_latency, instantiated only under the macro.

Verification
(Parameters TDEST=2, NUM_ROUTERS=4, TDATA_WIDTH=64.)
REQ-021 Release reset -> tready=1 one cycle later; all counters 0; error=0.
REQ-022 Single-beat packets from tid=1, sequence 0,1,2, tdest=2 -> recv_packets[1]=3, total=3, error=0.
REQ-023 Packet with tdest=3 -> error=1, and it stays 1 after further valid packets until rst.
REQ-024 tid=0 sends sequence 0 then 2 (gap) -> error=1; recv_packets[0]=2.
REQ-025 3-beat packet, tid changes on beat 2 -> error=1; total increments once, on beat 3.
REQ-026 With the macro defined: header timestamp 100, tlast accepted at ticks=130 -> max_latency=30, sum_latency=30.

Source files
------------

// File: rtl/axis_noc_pkg.sv
// Shared header layout for the AXI-Stream NoC traffic generator and checker.
// Header beat: low half of tdata = sequence number, high half = send timestamp.
package axis_noc_pkg;

   localparam int unsigned NocTdataWidth = 64;
   localparam int unsigned NocCountWidth = 32;

   // Width of each header field (sequence number and timestamp) for a given tdata width.
   function automatic int unsigned hdr_half_width(input int unsigned tdata_w);
      return tdata_w / 2;
   endfunction

   // Number of sequence bits actually compared against a packet counter.
   function automatic int unsigned seq_cmp_width(input int unsigned count_w,
                                                 input int unsigned tdata_w);
      return (count_w < tdata_w / 2) ? count_w : tdata_w / 2;
   endfunction

   localparam int unsigned HdrSeqWidth = hdr_half_width(NocTdataWidth);
   localparam int unsigned HdrTsWidth  = hdr_half_width(NocTdataWidth);
   localparam int unsigned SeqCmpWidth = seq_cmp_width(NocCountWidth, NocTdataWidth);

endpackage

// File: rtl/axis_checker_latency.sv
// Packet latency statistics: maximum and running sum of (ticks - header timestamp),
// sampled on every counted tlast beat. Only built when AXIS_CHECKER_LATENCY_STATS_EN is set.
module axis_checker_latency #(
   parameter int unsigned HALF_WIDTH = 32,
   parameter int unsigned SUM_WIDTH  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  beat_accept,
   input  logic                  is_header,
   input  logic                  tlast,
   input  logic [HALF_WIDTH-1:0] hdr_ts,
   input  logic [HALF_WIDTH-1:0] ticks,
   output logic [HALF_WIDTH-1:0] max_latency,
   output logic [SUM_WIDTH-1:0]  sum_latency
);

   logic [HALF_WIDTH-1:0] ts_q, ts_d;
   logic [HALF_WIDTH-1:0] max_q, max_d;
   logic [SUM_WIDTH-1:0]  sum_q, sum_d;
   logic [HALF_WIDTH-1:0] cur_ts;
   logic [HALF_WIDTH-1:0] latency;

   // Latch header timestamp and fold each finished packet's latency into the stats.
   always_comb begin
      ts_d    = ts_q;
      max_d   = max_q;
      sum_d   = sum_q;
      // A single-beat packet carries its own timestamp on the tlast beat.
      cur_ts  = is_header ? hdr_ts : ts_q;
      latency = ticks - cur_ts;
      if (beat_accept) begin
         if (is_header) begin
            ts_d = hdr_ts;
         end
         if (tlast) begin
            if (latency > max_q) begin
               max_d = latency;
            end
            sum_d = sum_q + SUM_WIDTH'(latency);
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q  <= '0;
         max_q <= '0;
         sum_q <= '0;
      end else begin
         ts_q  <= ts_d;
         max_q <= max_d;
         sum_q <= sum_d;
      end
   end

   assign max_latency = max_q;
   assign sum_latency = sum_q;

endmodule

// File: rtl/axis_checker.sv
// AXI-Stream NoC sink: checks header routing/sequence, body tid/tdest consistency,
// and counts packets per source. Never back-pressures.
// Optional latency statistics ports enabled by defining AXIS_CHECKER_LATENCY_STATS_EN.
module axis_checker
   import axis_noc_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH = 32,
   parameter int unsigned TDEST       = 0,
   parameter int unsigned TDATA_WIDTH = 64,
   parameter int unsigned TDEST_WIDTH = 2,
   parameter int unsigned TID_WIDTH   = 2,
   parameter int unsigned NUM_ROUTERS = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [TDATA_WIDTH/2-1:0]               ticks,
   input  logic                                   axis_in_tvalid,
   output logic                                   axis_in_tready,
   input  logic [TDATA_WIDTH-1:0]                 axis_in_tdata,
   input  logic                                   axis_in_tlast,
   input  logic [TID_WIDTH-1:0]                   axis_in_tid,
   input  logic [TDEST_WIDTH-1:0]                 axis_in_tdest,
   output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] recv_packets,
   output logic [COUNT_WIDTH-1:0]                 total_recv_packets,
`ifdef AXIS_CHECKER_LATENCY_STATS_EN
   output logic [TDATA_WIDTH/2-1:0]               max_latency,
   output logic [COUNT_WIDTH+TDATA_WIDTH/2-1:0]   sum_latency,
`endif
   output logic                                   error
);

   localparam int unsigned HalfW = hdr_half_width(TDATA_WIDTH);
   localparam int unsigned CmpW  = seq_cmp_width(COUNT_WIDTH, TDATA_WIDTH);

   logic                                   tready_q, tready_d;
   logic                                   in_packet_q, in_packet_d;
   logic                                   error_q, error_d;
   logic [TID_WIDTH-1:0]                   hdr_tid_q, hdr_tid_d;
   logic [TDEST_WIDTH-1:0]                 hdr_tdest_q, hdr_tdest_d;
   logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] recv_q, recv_d;
   logic [COUNT_WIDTH-1:0]                 total_q, total_d;

   logic                   accept;
   logic                   tid_ok;
   logic [COUNT_WIDTH-1:0] exp_seq;
   logic                   hdr_err;
   logic                   body_err;

   assign accept = axis_in_tvalid & tready_q;
   assign tid_ok = (32'(axis_in_tid) < NUM_ROUTERS);

   // Select the expected sequence number (current count) for the beat's source.
   always_comb begin
      exp_seq = '0;
      for (int i = 0; i < int'(NUM_ROUTERS); i++) begin
         if (int'(axis_in_tid) == i) begin
            exp_seq = recv_q[i];
         end
      end
   end

   assign hdr_err  = (axis_in_tdest != TDEST_WIDTH'(TDEST)) | ~tid_ok |
                     (axis_in_tdata[CmpW-1:0] != exp_seq[CmpW-1:0]);
   assign body_err = (axis_in_tid != hdr_tid_q) | (axis_in_tdest != hdr_tdest_q);

   // Next-state: packet framing, sticky error, and packet counters.
   always_comb begin
      tready_d    = 1'b1;
      in_packet_d = in_packet_q;
      error_d     = error_q;
      hdr_tid_d   = hdr_tid_q;
      hdr_tdest_d = hdr_tdest_q;
      recv_d      = recv_q;
      total_d     = total_q;
      if (accept) begin
         if (!in_packet_q) begin
            hdr_tid_d   = axis_in_tid;
            hdr_tdest_d = axis_in_tdest;
            if (hdr_err) begin
               error_d = 1'b1;
            end
         end else if (body_err) begin
            error_d = 1'b1;
         end
         in_packet_d = ~axis_in_tlast;
         if (axis_in_tlast) begin
            total_d = total_q + COUNT_WIDTH'(1);
            // Out-of-range tid matches no entry, so only the total advances.
            for (int i = 0; i < int'(NUM_ROUTERS); i++) begin
               if (int'(axis_in_tid) == i) begin
                  recv_d[i] = recv_q[i] + COUNT_WIDTH'(1);
               end
            end
         end
      end
   end

   // State registers; synchronous reset drops any partial packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         tready_q    <= 1'b0;
         in_packet_q <= 1'b0;
         error_q     <= 1'b0;
         hdr_tid_q   <= '0;
         hdr_tdest_q <= '0;
         recv_q      <= '0;
         total_q     <= '0;
      end else begin
         tready_q    <= tready_d;
         in_packet_q <= in_packet_d;
         error_q     <= error_d;
         hdr_tid_q   <= hdr_tid_d;
         hdr_tdest_q <= hdr_tdest_d;
         recv_q      <= recv_d;
         total_q     <= total_d;
      end
   end

   assign axis_in_tready     = tready_q;
   assign recv_packets       = recv_q;
   assign total_recv_packets = total_q;
   assign error              = error_q;

`ifdef AXIS_CHECKER_LATENCY_STATS_EN
   axis_checker_latency #(
      .HALF_WIDTH(HalfW),
      .SUM_WIDTH (COUNT_WIDTH + HalfW)
   ) u_latency (
      .clk        (clk),
      .rst        (rst),
      .beat_accept(accept),
      .is_header  (~in_packet_q),
      .tlast      (axis_in_tlast),
      .hdr_ts     (axis_in_tdata[TDATA_WIDTH-1:HalfW]),
      .ticks      (ticks),
      .max_latency(max_latency),
      .sum_latency(sum_latency)
   );
`endif

   // Payload bits beyond the compared sequence field are intentionally ignored.
   logic unused_bits;
   assign unused_bits = ^{ticks, axis_in_tdata};

endmodule

// File: tb/tb_axis_checker.sv
// Self-checking bench for axis_checker: directed scenarios plus randomized packet
// traffic compared against a packet-level reference model.
module tb_axis_checker;

   localparam int unsigned CW   = 8;
   localparam int unsigned TDW  = 64;
   localparam int unsigned HW   = TDW / 2;
   localparam int unsigned NR   = 4;
   localparam int unsigned DEST = 2;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [HW-1:0]              ticks;
   logic                       tvalid;
   logic                       tready;
   logic [TDW-1:0]             tdata;
   logic                       tlast;
   logic [1:0]                 tid;
   logic [1:0]                 tdest;
   logic [NR-1:0][CW-1:0]      recv_packets;
   logic [CW-1:0]              total_recv_packets;
   logic                       error;
`ifdef AXIS_CHECKER_LATENCY_STATS_EN
   logic [HW-1:0]              max_latency;
   logic [CW+HW-1:0]           sum_latency;
`endif

   always #5 clk = ~clk;

   axis_checker #(
      .COUNT_WIDTH(CW),
      .TDEST      (DEST),
      .TDATA_WIDTH(TDW),
      .TDEST_WIDTH(2),
      .TID_WIDTH  (2),
      .NUM_ROUTERS(NR)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .ticks             (ticks),
      .axis_in_tvalid    (tvalid),
      .axis_in_tready    (tready),
      .axis_in_tdata     (tdata),
      .axis_in_tlast     (tlast),
      .axis_in_tid       (tid),
      .axis_in_tdest     (tdest),
      .recv_packets      (recv_packets),
      .total_recv_packets(total_recv_packets),
`ifdef AXIS_CHECKER_LATENCY_STATS_EN
      .max_latency       (max_latency),
      .sum_latency       (sum_latency),
`endif
      .error             (error)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state (packet-level view).
   int unsigned m_recv[NR];
   int unsigned m_total;
   bit          m_err;
   bit          m_in_pkt;
   bit          m_ready;
   int unsigned m_hdr_tid;
   int unsigned m_hdr_dest;
   logic [31:0] m_hdr_ts;
   logic [31:0] m_max;
   logic [39:0] m_sum;
   logic [31:0] tick_cnt;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < int'(NR); i++) m_recv[i] = 0;
      m_total = 0; m_err = 0; m_in_pkt = 0; m_ready = 0;
      m_hdr_tid = 0; m_hdr_dest = 0; m_hdr_ts = '0; m_max = '0; m_sum = '0;
   endtask

   task automatic check_outputs();
      check_eq("tready", 64'(tready), 64'(m_ready));
      check_eq("total", 64'(total_recv_packets), 64'(m_total));
      check_eq("error", 64'(error), 64'(m_err));
      for (int i = 0; i < int'(NR); i++) begin
         check_eq($sformatf("recv%0d", i), 64'(recv_packets[i]), 64'(m_recv[i]));
      end
`ifdef AXIS_CHECKER_LATENCY_STATS_EN
      check_eq("max_latency", 64'(max_latency), 64'(m_max));
      check_eq("sum_latency", 64'(sum_latency), 64'(m_sum));
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1; tvalid = 1'b0; tdata = '0; tlast = 1'b0; tid = '0; tdest = '0;
      @(posedge clk); #1;
      model_reset();
      check_outputs();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      m_ready = 1;
      check_outputs();
   endtask

   // Drive one cycle of bus activity, then update the model and compare.
   task automatic send_beat(input bit v, input logic [63:0] d, input bit l,
                            input int unsigned t, input int unsigned ds);
      logic [31:0] seq;
      logic [31:0] lat;
      tvalid = v; tdata = d; tlast = l; tid = t[1:0]; tdest = ds[1:0]; ticks = tick_cnt;
      @(posedge clk); #1;
      if (v && m_ready) begin
         seq = d[31:0];
         if (!m_in_pkt) begin
            m_hdr_tid  = t;
            m_hdr_dest = ds;
            m_hdr_ts   = d[63:32];
            if (ds != DEST || t >= NR || (seq % (1 << CW)) != m_recv[t]) m_err = 1;
         end else if (t != m_hdr_tid || ds != m_hdr_dest) begin
            m_err = 1;
         end
         if (l) begin
            if (t < NR) m_recv[t] = (m_recv[t] + 1) % (1 << CW);
            m_total = (m_total + 1) % (1 << CW);
            lat = tick_cnt - m_hdr_ts;
            if (lat > m_max) m_max = lat;
            m_sum = m_sum + 40'(lat);
            m_in_pkt = 0;
         end else begin
            m_in_pkt = 1;
         end
      end
      tick_cnt = tick_cnt + 1;
      tvalid = 1'b0;
      check_outputs();
   endtask

   // Send a whole packet; header carries seq (with random bits above the compared width).
   task automatic send_pkt(input int unsigned t, input int unsigned len, input int unsigned ds,
                           input int unsigned seq, input logic [31:0] ts);
      logic [31:0] seq_field;
      logic [63:0] body;
      seq_field = 32'(seq) + (32'($urandom_range(0, 15)) << CW);
      send_beat(1'b1, {ts, seq_field}, len == 1, t, ds);
      for (int b = 1; b < int'(len); b++) begin
         body = {$urandom, $urandom};
         send_beat(1'b1, body, b == int'(len) - 1, t, ds);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] junk;
      int unsigned t;
      tick_cnt = 32'd1000;
      ticks = '0;
      do_reset();

      // Single-beat packets from tid 1, seq 0..2.
      for (int s = 0; s < 3; s++) send_pkt(1, 1, DEST, s, tick_cnt - 5);
      check_eq("seq_ok_recv1", 64'(recv_packets[1]), 64'd3);
      check_eq("seq_ok_total", 64'(total_recv_packets), 64'd3);
      check_eq("seq_ok_error", 64'(error), 64'd0);

      // Wrong tdest: error sets and stays set.
      send_pkt(1, 1, 3, 3, tick_cnt);
      check_eq("bad_dest_error", 64'(error), 64'd1);
      for (int s = 4; s < 7; s++) send_pkt(1, 2, DEST, s, tick_cnt);
      check_eq("sticky_error", 64'(error), 64'd1);
      check_eq("count_after_err", 64'(recv_packets[1]), 64'd7);

      // Sequence gap on tid 0.
      do_reset();
      send_pkt(0, 1, DEST, 0, tick_cnt);
      send_pkt(0, 1, DEST, 2, tick_cnt);
      check_eq("gap_error", 64'(error), 64'd1);
      check_eq("gap_recv0", 64'(recv_packets[0]), 64'd2);

      // tid changes mid-packet; total increments only on the last beat.
      do_reset();
      send_beat(1'b1, {32'd0, 32'd0}, 1'b0, 2, DEST);
      send_beat(1'b1, 64'h1234, 1'b0, 1, DEST);
      check_eq("tid_chg_error", 64'(error), 64'd1);
      check_eq("tid_chg_total_mid", 64'(total_recv_packets), 64'd0);
      send_beat(1'b1, 64'h5678, 1'b1, 2, DEST);
      check_eq("tid_chg_total_end", 64'(total_recv_packets), 64'd1);

      // Latency: header timestamp 100, tlast at ticks 130.
      do_reset();
      tick_cnt = 32'd110;
      send_beat(1'b1, {32'd100, 32'd0}, 1'b0, 0, DEST);
      tick_cnt = 32'd130;
      send_beat(1'b1, 64'h0, 1'b1, 0, DEST);
`ifdef AXIS_CHECKER_LATENCY_STATS_EN
      check_eq("lat_max30", 64'(max_latency), 64'd30);
      check_eq("lat_sum30", 64'(sum_latency), 64'd30);
`endif

      // Reset mid-packet leaves no residual framing state.
      send_beat(1'b1, {32'd0, 32'd1}, 1'b0, 3, DEST);
      do_reset();
      send_pkt(0, 1, DEST, 0, tick_cnt);
      check_eq("mid_rst_error", 64'(error), 64'd0);
      check_eq("mid_rst_recv0", 64'(recv_packets[0]), 64'd1);

      // Randomized clean traffic: back-to-back packets, idle gaps, counter wrap.
      do_reset();
      for (int p = 0; p < 1200; p++) begin
         if ($urandom_range(0, 3) == 0) begin
            junk = {$urandom, $urandom};
            send_beat(1'b0, junk, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
         end
         t = $urandom_range(0, NR - 1);
         send_pkt(t, $urandom_range(1, 4), DEST, m_recv[t], tick_cnt - $urandom_range(0, 40));
      end
      check_eq("rand_no_error", 64'(error), 64'd0);
      check_eq("rand_total", 64'(total_recv_packets), 64'(1200 % 256));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
